// File: rtl/clk_div_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master side drives enable and divisor loads; the slave side is the divider itself.
interface clk_div_prog_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
    logic             clk_div_out;
    logic             tick;
    logic [CNT_W-1:0] div_active;
    logic             div_pending;
    logic             err;

    modport master (
        output en, div_in, div_load,
        input  clk_div_out, tick, div_active, div_pending, err
    );

    modport slave (
        input  en, div_in, div_load,
        output clk_div_out, tick, div_active, div_pending, err
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with a 50% duty output for odd and even divisors.
// A new divisor is held pending and only takes effect at a period boundary.
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic          clk_in,
    input  logic          rst,
    clk_div_prog_if.slave bus
);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DEFAULT_DIV - 1);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_last;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] div_pend;
    logic [CNT_W-1:0] div_new;
    logic [CNT_W:0]   half;
    logic             div_pending;
    logic             err;
    logic             q_pos;
    logic             q_neg;
    logic             tick;
    logic             boundary;

    always_comb begin
        cnt_last = div_active - 1'b1;
        boundary = bus.en && div_pending && (cnt == cnt_last);
        div_new  = boundary ? div_pend : div_active;
        cnt_next = (cnt == cnt_last) ? '0 : cnt + 1'b1;
        // One extra bit so the largest divisor cannot overflow when rounding up.
        half     = ({1'b0, div_new} + 1'b1) >> 1;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt         <= CNT_RST;
            div_active  <= DIV_RST;
            div_pend    <= '0;
            div_pending <= 1'b0;
            err         <= 1'b0;
            q_pos       <= 1'b0;
            tick        <= 1'b0;
        end else begin
            if (bus.en) begin
                cnt   <= cnt_next;
                tick  <= (cnt_next == '0);
                q_pos <= ({1'b0, cnt_next} < half);
            end
            if (boundary) begin
                div_active  <= div_pend;
                div_pending <= 1'b0;
            end
            // A load on the boundary edge lands after the apply, so it waits one more period.
            if (bus.div_load) begin
                if (bus.div_in >= DIV_MIN) begin
                    div_pend    <= bus.div_in;
                    div_pending <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    // Half-cycle delayed copy trims the odd-divisor high phase by half a clk_in period.
    always_ff @(negedge clk_in) begin
        if (rst) begin
            q_neg <= 1'b0;
        end else if (bus.en) begin
            q_neg <= q_pos;
        end
    end

    assign bus.clk_div_out = div_active[0] ? (q_pos & q_neg) : q_pos;
    assign bus.tick        = tick;
    assign bus.div_active  = div_active;
    assign bus.div_pending = div_pending;
    assign bus.err         = err;
endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: cycle scoreboard against a behavioural model
// plus measured high/low/tick timing of the divided clock.
module tb_clk_div_prog;
    localparam int CNT_W = 8;
    localparam int DEF   = 5;

    logic clk_in = 1'b0;
    logic rst;

    clk_div_prog_if #(.CNT_W(CNT_W)) bus ();

    clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Behavioural reference state
    int m_cnt = DEF - 1, m_div = DEF, m_pend = 0, m_pending = 0, m_err = 0;
    int m_qpos = 0, m_qneg = 0, m_tick = 0;

    typedef struct {
        int tick;
        int div;
        int pending;
        int err;
        int out;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk_in) begin
        if (rst) m_qneg = 0;
        else if (bus.en) m_qneg = m_qpos;
    end

    // Timing of the divided clock and tick
    time t_rise = 0, t_fall = 0, t_tick = 0;
    int hi_ns = 0, lo_ns = 0, tick_per = 0;

    always @(posedge bus.clk_div_out) begin
        if (t_fall != 0) lo_ns = int'($time - t_fall);
        t_rise = $time;
    end
    always @(negedge bus.clk_div_out) begin
        hi_ns  = int'($time - t_rise);
        t_fall = $time;
    end
    always @(posedge bus.tick) begin
        if (t_tick != 0) tick_per = int'($time - t_tick);
        t_tick = $time;
    end

    task automatic model_edge();
        int bnd, dn, nc;
        exp_t e;
        if (rst) begin
            m_cnt = DEF - 1; m_div = DEF; m_pend = 0; m_pending = 0;
            m_err = 0; m_qpos = 0; m_tick = 0;
        end else begin
            bnd = (bus.en && m_pending && m_cnt == m_div - 1) ? 1 : 0;
            dn  = bnd ? m_pend : m_div;
            if (bus.en) begin
                nc     = (m_cnt == m_div - 1) ? 0 : m_cnt + 1;
                m_cnt  = nc;
                m_tick = (nc == 0) ? 1 : 0;
                m_qpos = (nc < ((dn + 1) >> 1)) ? 1 : 0;
            end
            if (bnd) begin
                m_div     = m_pend;
                m_pending = 0;
            end
            if (bus.div_load) begin
                if (int'(bus.div_in) >= 2) begin
                    m_pend    = int'(bus.div_in);
                    m_pending = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
        e.tick    = m_tick;
        e.div     = m_div;
        e.pending = m_pending;
        e.err     = m_err;
        e.out     = (m_div % 2 == 1) ? (m_qpos & m_qneg) : m_qpos;
        sbq.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk_in);
        model_edge();
        #1;
        e = sbq.pop_front();
        chk("tick",        int'(bus.tick),        e.tick);
        chk("div_active",  int'(bus.div_active),  e.div);
        chk("div_pending", int'(bus.div_pending), e.pending);
        chk("err",         int'(bus.err),         e.err);
        chk("clk_div_out", int'(bus.clk_div_out), e.out);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_cnt(input int v);
        int guard = 0;
        while (m_cnt != v && guard < 40) begin
            cycle();
            guard++;
        end
        chk("wait_cnt_reached", m_cnt, v);
    endtask

    task automatic load(input int d);
        bus.div_in   = CNT_W'(d);
        bus.div_load = 1'b1;
        cycle();
        bus.div_load = 1'b0;
    endtask

    task automatic timing(input string tag, input int hi, input int lo, input int per);
        chk({tag, "_high_ns"}, hi_ns, hi);
        chk({tag, "_low_ns"}, lo_ns, lo);
        chk({tag, "_tick_period_ns"}, tick_per, per);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b1;
        bus.div_in = '0;
        bus.div_load = 1'b0;
        run(3);
        chk("reset_div_active", int'(bus.div_active), DEF);
        chk("reset_out", int'(bus.clk_div_out), 0);
        rst = 1'b0;

        // Default divide-by-5
        run(20);
        timing("div5", 25, 25, 50);

        // 4 then 6 inside one period: 6 wins, old period completes
        wait_cnt(1);
        load(4);
        cycle();
        load(6);
        run(30);
        chk("div6_active", int'(bus.div_active), 6);
        timing("div6", 30, 30, 60);

        // Back to 5, then load 3 on the exact boundary edge
        load(5);
        run(14);
        wait_cnt(4);
        load(3);
        chk("boundary_load_pending", int'(bus.div_pending), 1);
        chk("boundary_load_not_applied", int'(bus.div_active), 5);
        run(30);
        timing("div3", 15, 15, 30);

        // Freeze for 7 cycles in the middle of a high phase
        wait_cnt(1);
        chk("freeze_start_high", int'(bus.clk_div_out), 1);
        bus.en = 1'b0;
        run(7);
        chk("freeze_held_high", int'(bus.clk_div_out), 1);
        bus.en = 1'b1;
        run(1);
        chk("freeze_high_ns", hi_ns, 85);
        run(10);

        // Illegal divisors set the sticky error and change nothing else
        load(1);
        load(0);
        chk("err_set", int'(bus.err), 1);
        chk("err_div_kept", int'(bus.div_active), 3);
        load(2);
        run(20);
        timing("div2", 10, 10, 20);
        chk("err_sticky", int'(bus.err), 1);

        // Reset in mid-period with a load pending
        wait_cnt(0);
        load(7);
        chk("pending_before_rst", int'(bus.div_pending), 1);
        rst = 1'b1;
        run(2);
        chk("rst_div_active", int'(bus.div_active), DEF);
        chk("rst_pending", int'(bus.div_pending), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_out", int'(bus.clk_div_out), 0);
        rst = 1'b0;
        run(20);
        timing("div5_after_rst", 25, 25, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
